// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Instruction-sequencing controller for the CPU program counter. It fetches
// one instruction word over a req/rdy handshake, latches it into the
// instruction register, and decodes the opcode. It then drives the PC
// control strobes to either step to the next instruction or jump.
//
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> FETCH ... ; HLT -> HALT.
//
// Parameters:
//   AW       PC / address width (default 12)
//   IW       instruction width (default 16); opcode = ir[IW-1:IW-4]
//   TIMEOUT  fetch wait limit in cycles (1..15), used only with
//            FETCH_TIMEOUT_EN
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   When defined, a stalled fetch gives up after TIMEOUT cycles and the
//   controller halts with fault=1.
//   When undefined, FETCH waits forever and fault is tied to 0.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   start      in   1   begin execution (sampled in IDLE only)
//   mem_req    out  1   instruction fetch request (high throughout FETCH)
//   mem_rdy    in   1   fetch acknowledge; instr valid in the same cycle
//   instr      in   IW  fetched instruction word
//   zero_flag  in   1   datapath zero flag, used by JZ in EXEC
//   ir         out  IW  instruction register
//   loadPC     out  1   PC load strobe
//   incPC      out  1   PC increment strobe
//   address    out  AW  jump target, always ir[AW-1:0]
//   exec_en    out  1   one-cycle execute strobe for non-control opcodes
//   icount     out  16  retired-instruction counter (wraps)
//   halted     out  1   high in HALT
//   fault      out  1   fetch timeout occurred (sticky until rst)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int AW      = 12,
  parameter int IW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          mem_req,
  input  logic          mem_rdy,
  input  logic [IW-1:0] instr,
  input  logic          zero_flag,
  output logic [IW-1:0] ir,
  output logic          loadPC,
  output logic          incPC,
  output logic [AW-1:0] address,
  output logic          exec_en,
  output logic [15:0]   icount,
  output logic          halted,
  output logic          fault
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JZ  = 4'hD;

  // The wait counter is 4 bits wide, so the limit must fit in it.
  generate
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range
      $error("pc_fetch_ctrl: TIMEOUT must be in 1..15");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [15:0]   icount_q, icount_d;

  logic [3:0] opcode;
  logic       fetch_timeout;

  assign opcode = ir_q[IW-1:IW-4];

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  logic [3:0] wait_q, wait_d;
  logic       fault_q, fault_d;

  // This is the last permitted empty FETCH cycle: the counter would reach
  // TIMEOUT at the closing edge. A same-cycle mem_rdy still completes the
  // fetch, because the timeout only fires when mem_rdy is low.
  assign fetch_timeout = (state_q == ST_FETCH) && !mem_rdy && (wait_q == WAIT_LAST);

  always_comb begin
    wait_d  = wait_q;
    fault_d = fault_q;
    if (state_q == ST_FETCH) begin
      if (!mem_rdy) begin
        wait_d = wait_q + 4'd1;
      end
      if (fetch_timeout) begin
        fault_d = 1'b1;
      end
    end
    // Clear on every entry into FETCH so each fetch gets a fresh budget.
    if (state_d == ST_FETCH && state_q != ST_FETCH) begin
      wait_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= 4'd0;
      fault_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fetch_timeout = 1'b0;
  assign fault         = 1'b0;
`endif

  // Next-state, instruction register and retired-instruction counter.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    icount_d = icount_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_rdy) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end else if (fetch_timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        icount_d = icount_q + 16'd1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      icount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
    end
  end

  // Strobes depend only on the registered state and ir, so nothing from
  // instr / mem_rdy / start reaches them combinationally. zero_flag is
  // deliberately consulted in EXEC only.
  always_comb begin
    mem_req = 1'b0;
    loadPC  = 1'b0;
    incPC   = 1'b0;
    exec_en = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      ST_FETCH: mem_req = 1'b1;
      ST_EXEC: begin
        if (opcode == OP_JMP) begin
          loadPC = 1'b1;
        end else if (opcode == OP_JZ) begin
          loadPC = zero_flag;
          incPC  = !zero_flag;
        end else begin
          exec_en = 1'b1;
          incPC   = 1'b1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign ir      = ir_q;
  assign address = ir_q[AW-1:0];
  assign icount  = icount_q;

endmodule
